// File: rtl/lsu_pkg.sv
// Shared types, access encodings and request-checking helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;

  localparam logic [7:0] TIMEOUT = 8'd255;

  function automatic logic legal_funct3(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction/extension and store replication/strobes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  store_strb
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    lane_b    = mem_rdata[{addr_lo, 3'b000} +: 8];
    lane_h    = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    store_data = wdata;
    store_strb = 4'b1111;
    case (funct3)
      F3_B: begin
        store_data = {4{wdata[7:0]}};
        store_strb = 4'b0001 << addr_lo;
      end
      F3_H: begin
        store_data = {2{wdata[15:0]}};
        store_strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = wdata;
        store_strb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-access load/store unit: checks a request, runs one memory handshake with timeout,
// and reports completion or fault with a one-cycle pulse.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start_read,
  input  logic        start_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [7:0]  wait_cnt;
  logic [1:0]  code_q;

  logic        start_any, start_one, req_illegal, req_misaligned, wait_expired;
  logic [31:0] load_data, store_data;
  logic [3:0]  store_strb;

  assign start_any      = start_read | start_write;
  assign start_one      = start_read ^ start_write;
  assign req_illegal    = (start_read & start_write) | ~legal_funct3(start_write, funct3);
  assign req_misaligned = misaligned(funct3, addr[1:0]);
  // The counter's last increment would land on TIMEOUT; an ack that same cycle still wins.
  assign wait_expired   = (wait_cnt == TIMEOUT - 8'd1);

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .mem_rdata  (mem_rdata),
    .load_data  (load_data),
    .store_data (store_data),
    .store_strb (store_strb)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_any) begin
          if (req_illegal || req_misaligned) state_next = FAULT;
          else                               state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack)           state_next = DONE;
        else if (wait_expired) state_next = FAULT;
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wait_cnt <= '0;
      code_q   <= FC_NONE;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_one) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            we_q     <= start_write;
          end
          if (start_any) begin
            wait_cnt <= '0;
            code_q   <= req_illegal ? FC_ILLEGAL : (req_misaligned ? FC_MISALIGN : FC_NONE);
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!we_q) rdata_q <= load_data;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_expired) code_q <= FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    fault_code = FC_NONE;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    case (state)
      ACCESS: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = we_q ? store_data : 32'd0;
        mem_wstrb = we_q ? store_strb : 4'b0000;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      FAULT: begin
        busy       = 1'b1;
        fault      = 1'b1;
        fault_code = code_q;
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_read = 1'b0, start_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        done, busy, fault, mem_req, mem_we;
  logic [1:0]  fault_code;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  load_store_unit dut (
    .clock(clock), .reset(reset), .start_read(start_read), .start_write(start_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .fault(fault), .fault_code(fault_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    start_read = rd; start_write = wr; funct3 = f3; addr = a; wdata = wd;
    step();
    start_read = 1'b0; start_write = 1'b0;
  endtask

  task automatic finish_ack(input logic [31:0] word);
    mem_rdata = word; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset;
    total++;
    if ({busy, done, fault, mem_req, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, fault, mem_req, mem_we});
    end
    total++;
    if ({rdata, mem_addr, mem_wdata, mem_wstrb, fault_code} !== '0) begin
      bad++; $display("FAIL reset_data: rdata=%h mem_addr=%h wdata=%h strb=%b code=%b want all 0",
                      rdata, mem_addr, mem_wdata, mem_wstrb, fault_code);
    end
  endtask

  task automatic test_lb;
    int busy_n = 0, done_n = 0;
    issue(1, 0, 3'b000, 32'h0000_0103, 0);
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h100, 4'b0000}) begin
      bad++; $display("FAIL lb_req: req=%b we=%b addr=%h strb=%b want 1 0 00000100 0000",
                      mem_req, mem_we, mem_addr, mem_wstrb);
    end
    mem_rdata = 32'h80FF_0000;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      mem_ack = (i == 2);
      step();
    end
    mem_ack = 1'b0;
    total++;
    if (busy_n !== 4) begin bad++; $display("FAIL lb_busy_cycles: got %0d want 4", busy_n); end
    total++;
    if (done_n !== 1) begin bad++; $display("FAIL lb_done_pulses: got %0d want 1", done_n); end
    total++;
    if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata: got %h want ffffff80", rdata); end
  endtask

  task automatic test_sh;
    issue(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !==
          {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD}) begin
        bad++; $display("FAIL sh_bus[%0d]: req=%b we=%b addr=%h strb=%b wdata=%h want 1 1 00000200 1100 abcdabcd",
                        i, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
      end
      step();
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL sh_done: got %b want 1", done); end
    step();
    total++;
    if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL sh_rdata_hold: got %h want ffffff80", rdata); end
  endtask

  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] word; logic [31:0] exp; } ld_vec_t;
  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] wd; logic [3:0] strb; logic [31:0] exp; } st_vec_t;

  task automatic test_load_lanes;
    ld_vec_t v[5];
    v[0] = '{3'b000, 32'h000, 32'h0000_007F, 32'h0000_007F};
    v[1] = '{3'b001, 32'h002, 32'h8000_0000, 32'hFFFF_8000};
    v[2] = '{3'b101, 32'h000, 32'h1234_F00D, 32'h0000_F00D};
    v[3] = '{3'b100, 32'h101, 32'h0000_9A00, 32'h0000_009A};
    v[4] = '{3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    foreach (v[i]) begin
      issue(1, 0, v[i].f3, v[i].a, 0);
      finish_ack(v[i].word);
      total++;
      if (rdata !== v[i].exp) begin
        bad++; $display("FAIL load_lane[%0d]: got %h want %h", i, rdata, v[i].exp);
      end
    end
  endtask

  task automatic test_store_lanes;
    st_vec_t v[4];
    v[0] = '{3'b000, 32'h001, 32'h1234_5678, 4'b0010, 32'h7878_7878};
    v[1] = '{3'b000, 32'h003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB};
    v[2] = '{3'b001, 32'h000, 32'h0000_1234, 4'b0011, 32'h1234_1234};
    v[3] = '{3'b010, 32'h008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
    foreach (v[i]) begin
      issue(0, 1, v[i].f3, v[i].a, v[i].wd);
      total++;
      if ({mem_wstrb, mem_wdata} !== {v[i].strb, v[i].exp}) begin
        bad++; $display("FAIL store_lane[%0d]: strb=%b wdata=%h want %b %h",
                        i, mem_wstrb, mem_wdata, v[i].strb, v[i].exp);
      end
      finish_ack(0);
    end
  endtask

  task automatic expect_fault(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a, input logic [1:0] code);
    issue(rd, wr, f3, a, 32'h5555_5555);
    total++;
    if ({fault, fault_code, mem_req, done} !== {1'b1, code, 1'b0, 1'b0}) begin
      bad++; $display("FAIL %s: fault=%b code=%b req=%b done=%b want 1 %b 0 0",
                      name, fault, fault_code, mem_req, done, code);
    end
    step();
    total++;
    if ({fault, busy, mem_req} !== 3'b000) begin
      bad++; $display("FAIL %s_after: fault=%b busy=%b req=%b want 000", name, fault, busy, mem_req);
    end
  endtask

  task automatic test_misaligned;
    expect_fault("lw_101", 1, 0, 3'b010, 32'h101, 2'b01);
    expect_fault("lh_003", 1, 0, 3'b001, 32'h003, 2'b01);
    expect_fault("sh_201", 0, 1, 3'b001, 32'h201, 2'b01);
  endtask

  task automatic test_illegal;
    expect_fault("both_starts", 1, 1, 3'b010, 32'h100, 2'b11);
    expect_fault("load_f3_011", 1, 0, 3'b011, 32'h100, 2'b11);
    expect_fault("store_f3_100", 0, 1, 3'b100, 32'h100, 2'b11);
    total++;
    if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rdata_hold_faults: got %h want deadbeef", rdata); end
  endtask

  task automatic test_timeout;
    int req_n = 0;
    logic seen = 1'b0;
    logic [1:0] code = 2'b00;
    issue(1, 0, 3'b010, 32'h100, 0);
    for (int i = 0; i < 300 && !seen; i++) begin
      if (mem_req) req_n++;
      if (fault) begin seen = 1'b1; code = fault_code; end
      else step();
    end
    total++;
    if (req_n !== 255) begin bad++; $display("FAIL timeout_req_cycles: got %0d want 255", req_n); end
    total++;
    if ({seen, code} !== {1'b1, 2'b10}) begin
      bad++; $display("FAIL timeout_fault: seen=%b code=%b want 1 10", seen, code);
    end
    step();
  endtask

  task automatic test_ack_at_limit;
    issue(1, 0, 3'b010, 32'h100, 0);
    for (int i = 0; i < 254; i++) step();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL limit_req_c255: got %b want 1", mem_req); end
    mem_rdata = 32'h1122_3344; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++;
    if ({done, fault} !== 2'b10) begin bad++; $display("FAIL limit_ack_wins: done/fault=%b want 10", {done, fault}); end
    step();
    total++;
    if (rdata !== 32'h1122_3344) begin bad++; $display("FAIL limit_rdata: got %h want 11223344", rdata); end
  endtask

  task automatic test_busy_ignore;
    int req_n = 0;
    issue(1, 0, 3'b010, 32'h100, 0);
    start_read = 1'b1; addr = 32'h200;
    step();
    start_read = 1'b0;
    total++;
    if (mem_addr !== 32'h100) begin bad++; $display("FAIL busy_addr_stable: got %h want 00000100", mem_addr); end
    finish_ack(32'h0BAD_F00D);
    for (int i = 0; i < 5; i++) begin
      if (mem_req || busy) req_n++;
      step();
    end
    total++;
    if (req_n !== 0) begin bad++; $display("FAIL busy_no_second_access: active cycles=%0d want 0", req_n); end
  endtask

  task automatic test_reset_mid_access;
    issue(1, 0, 3'b010, 32'h100, 0);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({mem_req, busy, rdata} !== {1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_async: req=%b busy=%b rdata=%h want 0 0 00000000", mem_req, busy, rdata);
    end
    #2 reset = 1'b1;
    step();
    issue(1, 0, 3'b101, 32'h002, 0);
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL post_reset_req: req=%b addr=%h want 1 00000000", mem_req, mem_addr);
    end
    finish_ack(32'h8001_0000);
    total++;
    if (rdata !== 32'h0000_8001) begin bad++; $display("FAIL post_reset_lhu: got %h want 00008001", rdata); end
  endtask

  initial begin
    repeat (2) step();
    test_reset();
    reset = 1'b1;
    step();
    test_lb();
    test_sh();
    test_load_lanes();
    test_store_lanes();
    test_misaligned();
    test_illegal();
    test_timeout();
    test_ack_at_limit();
    test_busy_ignore();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clock  in  1  single system clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-003 start_read  in  1  load request from control unit, sampled in IDLE only.
REQ-004 start_write  in  1  store request from control unit, sampled in IDLE only.
REQ-005 funct3  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-006 addr  in  32  byte address of the access.
REQ-007 wdata  in  32  store data, right-aligned.
REQ-008 rdata  out  32  formatted load result, right-aligned and extended.
REQ-009 done  out  1  one-cycle pulse: access completed.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 fault  out  1  one-cycle pulse: access rejected or timed out.
REQ-012 fault_code  out  2  01 misaligned, 10 timeout, 11 illegal request; valid while fault=1.
REQ-013 mem_req  out  1  memory request, held until mem_ack.
REQ-014 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-015 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_wstrb  out  4  byte enables; 0000 on reads.
REQ-018 mem_rdata  in  32  memory read word, valid when mem_ack=1.
REQ-019 mem_ack  in  1  memory completion, sampled only in ACCESS.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, DONE and FAULT.
REQ-021 IDLE with exactly one start high SHALL register addr, funct3 and wdata and SHALL check the request that cycle.
REQ-022 Both starts high, a load funct3 of 011/110/111, or a store funct3 other than 000/001/010 SHALL go to FAULT with code 11.
REQ-023 Halfword access with addr[0]=1, or word access with addr[1:0]!=00, SHALL go to FAULT with code 01 and SHALL NOT assert mem_req.
REQ-024 Legal requests SHALL go to ACCESS and assert mem_req from the next cycle.
REQ-025 mem_addr, mem_we, mem_wdata and mem_wstrb SHALL stay stable while mem_req=1.
REQ-026 In ACCESS, mem_ack=1 SHALL deassert mem_req on the next edge and move to DONE; a load SHALL capture formatted rdata on the same edge.
REQ-027 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-028 If the counter reaches 255 without ack, the FSM SHALL go to FAULT with code 10 and drop mem_req.
REQ-029 mem_ack arriving in the same cycle the counter reaches 255 SHALL win and complete normally.
REQ-030 DONE SHALL assert done for one cycle and return to IDLE; FAULT SHALL assert fault for one cycle and return to IDLE.
REQ-031 Starts seen while busy=1 SHALL be ignored and not queued.
REQ-032 Load lane SHALL be addr[1:0] for bytes and addr[1] for halfwords; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-033 SB SHALL use wstrb 0001<<addr[1:0] with the byte replicated x4; SH SHALL use 0011 or 1100 by addr[1] with the half replicated x2; SW SHALL use 1111.
REQ-034 rdata SHALL hold its value until the next completed load.

Reset
REQ-035 reset=0 SHALL immediately force IDLE, counter=0, rdata=0 and all other outputs to 0, including mem_req during ACCESS.
REQ-036 After reset is released, the first legal start SHALL behave as from a fresh IDLE.

Structure
REQ-037 The package lsu_pkg SHALL hold the state enum, funct3 constants, fault codes and TIMEOUT=255.
REQ-038 Lane steering and extension SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-039 LB at addr 0x103, mem_rdata 0x80FF_0000, ack after 2 cycles -> rdata 0xFFFF_FF80, done pulses once, busy for 4 cycles.
REQ-040 SH at addr 0x202, wdata 0x0000_ABCD -> mem_addr 0x200, wstrb 1100, mem_wdata 0xABCD_ABCD.
REQ-041 LW at addr 0x101 -> fault=1 with code 01 the next cycle, mem_req never asserted.
REQ-042 LW with mem_ack held low -> mem_req drops after 255 ACCESS cycles, fault with code 10.
REQ-043 reset pulled low mid-ACCESS -> mem_req=0 immediately; a new LHU at 0x002 with rdata 0x8001_0000 -> rdata 0x0000_8001.
REQ-044 start_read and start_write high together -> fault with code 11; start_read pulsed while busy -> no second access.
